// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx among NUM_REQ byte streams
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic [IW-1:0]   pick, nxt;
    logic            found, xfer, release_now;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % NUM_REQ);
    endfunction

    assign nxt  = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign busy = |grant;

    // First asserted requester at or after rr_q; the reverse scan lets the nearest one win.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap(int'(rr_q) + k)]) begin
                pick  = wrap(int'(rr_q) + k);
                found = 1'b1;
            end
        end
    end

    // Next state, counters and the combinational pass-through from owner to uart_tx.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        burst_d     = burst_q;
        idle_d      = idle_q;
        grant       = '0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        req_ready   = '0;
        xfer        = 1'b0;
        release_now = 1'b0;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = OWNED;
                owner_d = pick;
                burst_d = '0;
                idle_d  = '0;
            end
        end else begin
            grant[owner_q]     = 1'b1;
            tx_valid           = req_valid[owner_q];
            tx_data            = req_data[{owner_q, 3'b000} +: 8];
            req_ready[owner_q] = tx_ready;
            xfer               = tx_valid && tx_ready;
            burst_d            = burst_q + BW'(xfer);
            idle_d             = req_valid[owner_q] ? '0 : idle_q + 1'b1;
            release_now        = (xfer && (req_last[owner_q] || burst_q == BW'(MAX_BURST - 1)))
                              || (!req_valid[owner_q] && idle_q == TW'(IDLE_TIMEOUT - 1));
            if (release_now) begin
                state_d = IDLE;
                rr_d    = nxt;
            end
        end
    end

    // State register; reset abandons any message and restarts arbitration at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            burst_q <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            idle_q  <= idle_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table plus directed sequences for uart_tx_arbiter
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic        tx_ready = 1'b0;
    logic [3:0]  req_ready, grant;
    logic        tx_valid, busy;
    logic [7:0]  tx_data;
    int total = 0;
    int bad = 0;
    int xfers = 0;
    int stall_bad = 0;

    typedef struct {
        logic        r;
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        tr;
        logic [3:0]  g;
        logic        tv;
        logic [7:0]  td;
        logic [3:0]  rd;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(4), .IDLE_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .grant(grant), .busy(busy)
    );

    task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                       input logic tr, input logic [3:0] g, input logic tv, input logic [7:0] td,
                       input logic [3:0] rd);
        vec_t e;
        e.r = r; e.v = v; e.d = d; e.l = l; e.tr = tr; e.g = g; e.tv = tv; e.td = td; e.rd = rd;
        tbl.push_back(e);
    endtask

    task automatic step(input logic r, input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                        input logic tr);
        @(negedge clk);
        rst = r; req_valid = v; req_data = d; req_last = l; tx_ready = tr;
        #1;
        if (tx_valid && tx_ready) xfers++;
    endtask

    task automatic chk(input string n, input logic [3:0] g, input logic tv, input logic [7:0] td,
                       input logic [3:0] rd);
        total++;
        if (grant !== g || tx_valid !== tv || tx_data !== td || req_ready !== rd || busy !== (g != 4'b0)) begin
            bad++;
            $display("FAIL %s: got grant=%b tx_valid=%b tx_data=%h req_ready=%b busy=%b, want grant=%b tx_valid=%b tx_data=%h req_ready=%b",
                     n, grant, tx_valid, tx_data, req_ready, busy, g, tv, td, rd);
        end
    endtask

    task automatic chk_n(input string n, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", n, got, want);
        end
    endtask

    initial begin
        // single requester 1, three bytes
        add(1, 4'b0010, 32'h00003100, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000);
        add(0, 4'b0010, 32'h00003100, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000);
        add(0, 4'b0010, 32'h00003100, 4'b0000, 1, 4'b0010, 1, 8'h31, 4'b0010);
        add(0, 4'b0010, 32'h00003200, 4'b0000, 1, 4'b0010, 1, 8'h32, 4'b0010);
        add(0, 4'b0010, 32'h00003300, 4'b0010, 1, 4'b0010, 1, 8'h33, 4'b0010);
        add(0, 4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000);
        // round robin, all four requesting one-byte messages
        add(1, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1, 4'b0000, 0, 8'h00, 4'b0000);
        add(0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1, 4'b0000, 0, 8'h00, 4'b0000);
        add(0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1, 4'b0001, 1, 8'hA0, 4'b0001);
        add(0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1, 4'b0000, 0, 8'h00, 4'b0000);
        add(0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1, 4'b0010, 1, 8'hA1, 4'b0010);
        add(0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1, 4'b0000, 0, 8'h00, 4'b0000);
        add(0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1, 4'b0100, 1, 8'hA2, 4'b0100);
        add(0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1, 4'b0000, 0, 8'h00, 4'b0000);
        add(0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1, 4'b1000, 1, 8'hA3, 4'b1000);
        add(0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1, 4'b0000, 0, 8'h00, 4'b0000);
        add(0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1, 4'b0001, 1, 8'hA0, 4'b0001);
        add(0, 4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000);
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].tr);
            chk($sformatf("vec%0d", i), tbl[i].g, tbl[i].tv, tbl[i].td, tbl[i].rd);
        end

        // backpressure on owner 2 for 500 cycles
        step(1, 4'b0000, 32'h0, 4'b0000, 0);
        chk("bp_rst", 4'b0000, 0, 8'h00, 4'b0000);
        step(0, 4'b0100, 32'h00810000, 4'b0100, 0);
        chk("bp_arb", 4'b0000, 0, 8'h00, 4'b0000);
        xfers = 0;
        repeat (500) begin
            step(0, 4'b0100, 32'h00810000, 4'b0100, 0);
            if (grant !== 4'b0100 || req_ready !== 4'b0000 || tx_valid !== 1'b1 || tx_data !== 8'h81) stall_bad++;
        end
        chk_n("bp_stall", stall_bad, 0);
        step(0, 4'b0100, 32'h00810000, 4'b0100, 1);
        chk("bp_go", 4'b0100, 1, 8'h81, 4'b0100);
        step(0, 4'b0000, 32'h0, 4'b0000, 1);
        chk("bp_rel", 4'b0000, 0, 8'h00, 4'b0000);
        chk_n("bp_xfers", xfers, 1);

        // burst limit 4: requester 0 six bytes, requester 3 waiting
        step(1, 4'b0000, 32'h0, 4'b0000, 1);
        chk("bl_rst", 4'b0000, 0, 8'h00, 4'b0000);
        step(0, 4'b1001, 32'hC30000B1, 4'b1000, 1);
        chk("bl_arb", 4'b0000, 0, 8'h00, 4'b0000);
        for (int b = 1; b <= 4; b++) begin
            step(0, 4'b1001, 32'hC30000B0 | 32'(b), 4'b1000, 1);
            chk($sformatf("bl_b%0d", b), 4'b0001, 1, 8'hB0 | 8'(b), 4'b0001);
        end
        step(0, 4'b1001, 32'hC30000B5, 4'b1000, 1);
        chk("bl_rel", 4'b0000, 0, 8'h00, 4'b0000);
        step(0, 4'b1001, 32'hC30000B5, 4'b1000, 1);
        chk("bl_r3", 4'b1000, 1, 8'hC3, 4'b1000);
        step(0, 4'b0001, 32'h000000B5, 4'b0000, 1);
        chk("bl_gap", 4'b0000, 0, 8'h00, 4'b0000);
        step(0, 4'b0001, 32'h000000B5, 4'b0000, 1);
        chk("bl_b5", 4'b0001, 1, 8'hB5, 4'b0001);
        step(0, 4'b0001, 32'h000000B6, 4'b0001, 1);
        chk("bl_b6", 4'b0001, 1, 8'hB6, 4'b0001);
        step(0, 4'b0000, 32'h0, 4'b0000, 1);
        chk("bl_end", 4'b0000, 0, 8'h00, 4'b0000);

        // idle timeout 8 on owner 1
        step(1, 4'b0000, 32'h0, 4'b0000, 1);
        chk("to_rst", 4'b0000, 0, 8'h00, 4'b0000);
        step(0, 4'b0010, 32'h00005100, 4'b0000, 1);
        chk("to_arb", 4'b0000, 0, 8'h00, 4'b0000);
        step(0, 4'b0010, 32'h00005100, 4'b0000, 1);
        chk("to_byte", 4'b0010, 1, 8'h51, 4'b0010);
        for (int c = 0; c < 8; c++) begin
            step(0, 4'b0000, 32'h0, 4'b0000, 1);
            chk($sformatf("to_hold%0d", c), 4'b0010, 0, 8'h00, 4'b0010);
        end
        step(0, 4'b0111, 32'h00E2E1E0, 4'b0111, 1);
        chk("to_rel", 4'b0000, 0, 8'h00, 4'b0000);
        step(0, 4'b0111, 32'h00E2E1E0, 4'b0111, 1);
        chk("to_rr", 4'b0100, 1, 8'hE2, 4'b0100);

        // reset in the middle of owner 3's message
        step(1, 4'b0000, 32'h0, 4'b0000, 1);
        chk("mr_rst", 4'b0000, 0, 8'h00, 4'b0000);
        step(0, 4'b1000, 32'hD1000000, 4'b0000, 1);
        chk("mr_arb", 4'b0000, 0, 8'h00, 4'b0000);
        step(0, 4'b1000, 32'hD1000000, 4'b0000, 1);
        chk("mr_b1", 4'b1000, 1, 8'hD1, 4'b1000);
        step(1, 4'b1000, 32'hD2000000, 4'b0000, 1);
        chk("mr_abort", 4'b0000, 0, 8'h00, 4'b0000);
        step(0, 4'b1001, 32'hD20000F0, 4'b0000, 1);
        chk("mr_idle", 4'b0000, 0, 8'h00, 4'b0000);
        step(0, 4'b1001, 32'hD20000F0, 4'b0000, 1);
        chk("mr_r0", 4'b0001, 1, 8'hF0, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one uart_tx (2..8).
REQ-002 Parameter MAX_BURST, default 16: max bytes per grant before forced release (1..255).
REQ-003 Parameter IDLE_TIMEOUT, default 1024: cycles the granted requester may hold valid low before release (1..65535).
REQ-004 clk  input  1  system clock; all state changes on posedge clk.
REQ-005 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-007 req_data  input  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i].
REQ-008 req_last  input  NUM_REQ  marks final byte of requester's message.
REQ-009 req_ready  output  NUM_REQ  per-requester accept.
REQ-010 tx_valid  output  1  byte valid to uart_tx.
REQ-011 tx_data  output  8  byte to uart_tx data_to_send.
REQ-012 tx_ready  input  1  uart_tx ready.
REQ-013 grant  output  NUM_REQ  one-hot current owner; all-zero when idle.
REQ-014 busy  output  1  high whenever grant is non-zero.

Function
REQ-015 The block SHALL implement two states: IDLE and OWNED.
REQ-016 In IDLE, grant, tx_valid and req_ready SHALL all be 0.
REQ-017 In IDLE, if any req_valid is high, the block SHALL select the first asserted index at or after rr_ptr (wrapping NUM_REQ-1 -> 0), register it as grant and enter OWNED on the next edge (1-cycle arbitration latency).
REQ-018 In OWNED with owner g: tx_valid = req_valid[g], tx_data = req_data[g], req_ready[g] = tx_ready, and req_ready for all other requesters SHALL be 0 (combinational pass-through, zero added latency).
REQ-019 A transfer SHALL occur on a cycle where tx_valid and tx_ready are both high; only transfers advance burst_cnt.
REQ-020 On a transfer with req_last[g]=1, the block SHALL return to IDLE next edge and set rr_ptr = (g+1) mod NUM_REQ.
REQ-021 On the transfer that makes burst_cnt reach MAX_BURST, the block SHALL release to IDLE and set rr_ptr = (g+1) mod NUM_REQ, even if req_last[g]=0; the requester re-arbitrates for the rest of its message.
REQ-022 In OWNED, idle_cnt SHALL count consecutive cycles with req_valid[g]=0, clear on any cycle with req_valid[g]=1, and on reaching IDLE_TIMEOUT force release to IDLE with rr_ptr = (g+1) mod NUM_REQ.
REQ-023 If release by last, burst limit and timeout coincide, the result SHALL be identical (one release, same rr_ptr).
REQ-024 burst_cnt and idle_cnt SHALL clear on every entry to OWNED; burst_cnt width SHALL hold MAX_BURST without wrap.
REQ-025 Requests from non-owners SHALL be ignored during OWNED; they are not latched and are only evaluated in IDLE.
REQ-026 Minimum gap between one message's last byte and the next owner's first tx_valid SHALL be exactly 1 cycle (the IDLE arbitration cycle).
REQ-027 tx_valid SHALL NOT be asserted for any cycle where grant is zero; grant SHALL never have more than one bit set.

Reset
REQ-028 While rst is high: state IDLE, grant=0, rr_ptr=0, burst_cnt=0, idle_cnt=0, busy=0, tx_valid=0, req_ready=0, tx_data=0.
REQ-029 Reset asserted mid-message SHALL abandon the message immediately; after release, arbitration restarts from index 0.

Verification
REQ-030 Single requester: req_valid[1]=1, 3 bytes 0x31,0x32,0x33 with last on 0x33, tx_ready always 1 -> grant=0010 one cycle after request, bytes appear on tx_data consecutively, grant=0 the cycle after 0x33.
REQ-031 Round-robin: all four req_valid held high, each sending 1-byte messages with last=1 -> grant order 0,1,2,3,0, each separated by one IDLE cycle.
REQ-032 Backpressure: owner 2 sending 0x81, tx_ready low 500 cycles then high -> req_ready[2]=0 throughout stall, exactly one transfer, no timeout (valid stayed high).
REQ-033 Burst limit MAX_BURST=4: requester 0 sends 6 bytes, last on byte 6, requester 3 also requesting -> release after byte 4, requester 3 served next, requester 0 resumes with bytes 5-6.
REQ-034 Timeout IDLE_TIMEOUT=8: owner 1 sends one byte without last then drops valid -> release exactly 8 cycles after valid falls, rr_ptr=2.
REQ-035 Reset mid-message: assert rst during owner 3's second byte -> all outputs 0 immediately; after deassert with req 0 and 3 valid, requester 0 granted first.
